// File: rtl/risc_pkg.sv
// Shared RISC-16 definitions: instruction memory geometry and the
// boot loader state encoding, reused by the core, the memory and the loader.
package risc_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int INSTR_W     = 16;
    localparam int BYTE_W      = 8;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LEN_HI  = 4'd1,
        S_LEN_LO  = 4'd2,
        S_DAT_HI  = 4'd3,
        S_DAT_LO  = 4'd4,
        S_WRITE   = 4'd5,
        S_DONE    = 4'd6,
        S_ERR     = 4'd7,
        S_CHK     = 4'd8
    } loader_state_e;

    // States in which the loader is willing to take a stream byte.
    function automatic logic accepts_byte(input loader_state_e s);
        return (s inside {S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_CHK});
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus bundle: incoming byte stream (valid/ready) plus the
// instruction memory write port.
interface imem_loader_if
    import risc_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) ();

    logic [BYTE_W-1:0]  rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_wdata;

    // Loader side: consumes the stream, drives the memory write port.
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );

    // Host side: produces the stream, observes the memory writes.
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_byte_rx.sv
// Byte handshake and big-endian word assembler for the loader. The FSM says
// when bytes may be taken and which half is expected; this block latches the
// high byte and emits a one-cycle word_valid after each completed data word.
module imem_byte_rx
    import risc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_en,        // loader will take a byte
    input  logic               i_hi,        // expected byte is a high half
    input  logic               i_dat_lo,    // expected byte completes a data word
    input  logic [BYTE_W-1:0]  i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_rx_ready,
    output logic               o_accept,    // a byte transfers on this edge
    output logic [15:0]        o_pair,      // {latched hi, current byte}
    output logic               o_word_valid,
    output logic [INSTR_W-1:0] o_word
);

    logic [BYTE_W-1:0]  r_hi;
    logic               r_word_valid;
    logic [INSTR_W-1:0] r_word;

    assign o_rx_ready   = i_en;
    assign o_accept     = i_en & i_rx_valid;
    assign o_pair       = {r_hi, i_rx_data};
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

    // Latch high bytes; register completed data words and their strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi         <= '0;
            r_word_valid <= 1'b0;
            r_word       <= '0;
        end else begin
            // NOTE: non-blocking so every flop here samples pre-edge values.
            r_word_valid <= o_accept & i_dat_lo;
            if (o_accept && i_hi) begin
                r_hi <= i_rx_data;
            end
            if (o_accept && i_dat_lo) begin
                r_word <= {r_hi, i_rx_data};
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time RISC-16 instruction memory loader. Stream format: 16-bit word
// count N (big-endian), then N big-endian words written from address 0.
// The core is held in reset until a load completes successfully.
// Optional: define IMEM_LOADER_CHECKSUM_EN to require a trailing byte equal
// to the XOR of all data bytes before the load is accepted.
module imem_loader
    import risc_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int MAX_WORDS = 256
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    imem_loader_if.slave   bus,
    output logic           cpu_reset,
    output logic           busy,
    output logic           done,
    output logic           error
);

    // One extra bit so a full 2**ADDR_W program does not alias to zero.
    localparam int          IDX_W = ADDR_W + 1;
    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    loader_state_e      r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_len_m1;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_cpu_reset;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]  r_chk;
`endif

    logic               w_rx_en;
    logic               w_hi;
    logic               w_dat_lo;
    logic               w_accept;
    logic [15:0]        w_pair;
    logic               w_word_valid;
    logic [INSTR_W-1:0] w_word;

    assign w_rx_en  = accepts_byte(r_state);
    assign w_hi     = (r_state == S_LEN_HI) || (r_state == S_DAT_HI);
    assign w_dat_lo = (r_state == S_DAT_LO);

    imem_byte_rx u_byte_rx (
        .clk          (clk),
        .reset        (reset),
        .i_en         (w_rx_en),
        .i_hi         (w_hi),
        .i_dat_lo     (w_dat_lo),
        .i_rx_data    (bus.rx_data),
        .i_rx_valid   (bus.rx_valid),
        .o_rx_ready   (bus.rx_ready),
        .o_accept     (w_accept),
        .o_pair       (w_pair),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // The write strobe and data come straight from the assembler; the
    // address is captured together with the word so it holds outside WRITE.
    assign bus.mem_we    = w_word_valid;
    assign bus.mem_wdata = w_word;
    assign bus.mem_addr  = r_mem_addr;

    assign cpu_reset = r_cpu_reset;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;

    // Load sequencer with registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_len_m1    <= '0;
            r_mem_addr  <= '0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_chk       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_LEN_HI;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_cpu_reset <= 1'b1;
                        r_idx       <= '0;
                        r_len_m1    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_chk       <= '0;
`endif
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) r_state <= S_LEN_LO;
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        if (w_pair == '0 || w_pair > MAX_N) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_len_m1 <= IDX_W'(w_pair - 16'd1);
                            r_state  <= S_DAT_HI;
                        end
                    end
                end
                S_DAT_HI: begin
                    if (w_accept) begin
                        r_state <= S_DAT_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_chk   <= r_chk ^ bus.rx_data;
`endif
                    end
                end
                S_DAT_LO: begin
                    if (w_accept) begin
                        r_state    <= S_WRITE;
                        r_mem_addr <= r_idx[ADDR_W-1:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_chk      <= r_chk ^ bus.rx_data;
`endif
                    end
                end
                S_WRITE: begin
                    if (r_idx == r_len_m1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_state     <= S_CHK;
`else
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cpu_reset <= 1'b0;
`endif
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= S_DAT_HI;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (w_accept) begin
                        r_busy <= 1'b0;
                        if (bus.rx_data == r_chk) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random programs with
// random stream gaps, compared against a stream-level model of the load.
// Honours IMEM_LOADER_CHECKSUM_EN when the design is built with it.
module tb_imem_loader;
    import risc_pkg::*;

    localparam int AW   = IMEM_ADDR_W;
    localparam int MAXW = 256;

    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic cpu_reset, busy, done, error;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(.ADDR_W(AW), .MAX_WORDS(MAXW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus.slave),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [23:0] wq [$];

    // Record every memory write seen away from the clock edge.
    always @(negedge clk) begin
        if (reset && bus.mem_we) wq.push_back({bus.mem_addr, bus.mem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Random program of n words, with a trailing checksum when enabled.
    function automatic bq_t make_prog(input int n, input bit bad_chk);
        bq_t q;
        logic [7:0] b;
        logic [7:0] x;
        q = {};
        x = 8'h00;
        q.push_back(8'((n >> 8) & 255));
        q.push_back(8'(n & 255));
        for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            x = x ^ b;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        q.push_back(bad_chk ? (x ^ 8'h01) : x);
`else
        if (bad_chk) q.push_back(x);
`endif
        return q;
    endfunction

    // Offer one byte after a random idle gap; returns at the negedge after it transferred.
    task automatic send_byte(input logic [7:0] b, input int gap_max, output bit ok);
        int t;
        int g;
        t = 0;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        bus.rx_valid = 1'b0;
        repeat (g) @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (!bus.rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        ok = bus.rx_ready;
        if (ok) @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    // Start a load, stream s, and compare the outcome with the model.
    task automatic run_load(input bq_t s, input int gap_max, input bit poke_start, input string name);
        int n;
        int t;
        int exp_writes;
        bit len_ok;
        bit exp_ok;
        bit all_ok;
        bit ok;
        logic [7:0] x;
        logic [23:0] e;

        n      = (int'(s[0]) << 8) | int'(s[1]);
        len_ok = (n >= 1) && (n <= MAXW);
        exp_ok = len_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (len_ok) begin
            x = 8'h00;
            for (int i = 0; i < 2 * n; i++) x = x ^ s[2 + i];
            exp_ok = (s[2 + 2 * n] == x);
        end
`endif
        exp_writes = len_ok ? n : 0;

        wq.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("%s:busy_on", name), {busy, cpu_reset, done, error}, 4'b1100);

        all_ok = 1'b1;
        foreach (s[i]) begin
            if (all_ok) begin
                send_byte(s[i], gap_max, ok);
                all_ok = ok;
            end
        end
        check($sformatf("%s:bytes_taken", name), all_ok, 1'b1);

        if (all_ok && exp_ok) begin
`ifndef IMEM_LOADER_CHECKSUM_EN
            check($sformatf("%s:last_we", name), bus.mem_we, 1'b1);
            @(negedge clk);
`endif
            check($sformatf("%s:release", name), {done, cpu_reset, busy}, 3'b100);
            if (poke_start) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check($sformatf("%s:idle_after", name), {busy, done, cpu_reset, bus.rx_ready}, 4'b0100);
        end else begin
            t = 0;
            while (busy && t < 40) begin
                @(negedge clk);
                t++;
            end
            check($sformatf("%s:finished", name), busy, 1'b0);
        end

        repeat (3) @(negedge clk);
        check($sformatf("%s:status", name), {done, error, cpu_reset, busy},
              {exp_ok, !exp_ok, !exp_ok, 1'b0});
        check($sformatf("%s:n_writes", name), wq.size(), exp_writes);
        for (int i = 0; i < exp_writes && i < wq.size(); i++) begin
            e = {8'(i), s[2 + 2 * i], s[3 + 2 * i]};
            check($sformatf("%s:write%0d", name, i), wq[i], e);
        end
    endtask

    task automatic check_reset_values(input string name);
        check($sformatf("%s:ctl", name),
              {bus.rx_ready, bus.mem_we, cpu_reset, busy, done, error}, 6'b001000);
        check($sformatf("%s:addr", name), bus.mem_addr, '0);
        check($sformatf("%s:wdata", name), bus.mem_wdata, '0);
    endtask

    initial begin
        bq_t basic;
        bq_t q;
        bit ok;

        reset        = 1'b0;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        @(negedge clk);

        basic = '{8'h00, 8'h02, 8'h12, 8'h05, 8'h23, 8'h03};
`ifdef IMEM_LOADER_CHECKSUM_EN
        basic.push_back(8'h37);
`endif
        run_load(basic, 0, 1'b1, "basic");
        run_load(basic, 3, 1'b0, "gaps");

        q = '{8'h00, 8'h00};
        run_load(q, 1, 1'b0, "zero_len");
        q = '{8'h01, 8'h01};
        run_load(q, 0, 1'b0, "over_len");

        run_load(make_prog(MAXW, 1'b0), 0, 1'b0, "max_len");
        for (int k = 0; k < 6; k++) begin
            run_load(make_prog(int'($urandom_range(8, 1)), 1'b0), int'($urandom_range(3, 0)),
                     1'b0, $sformatf("rand%0d", k));
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        q = '{8'h00, 8'h01, 8'h12, 8'h05, 8'h17};
        run_load(q, 0, 1'b0, "chk_ok");
        q = '{8'h00, 8'h01, 8'h12, 8'h05, 8'h16};
        run_load(q, 2, 1'b0, "chk_bad");
        run_load(make_prog(5, 1'b1), 1, 1'b0, "chk_rand_bad");
`endif

        // Reset in the middle of a load, after three data bytes.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        foreach (basic[i]) begin
            if (i < 5) send_byte(basic[i], 0, ok);
        end
        check("midload:busy", busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("midload_rst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_load(basic, 2, 1'b0, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
